// File: rtl/ptp_stream_bridge.sv
// ptp_stream_bridge: host-strobed parallel bridge between the BUS_W-bit host
// pins and WORD_W-bit core words. Load strobes assemble words MSB chunk first;
// read strobes walk a coherent snapshot of OUT_WORDS core words chunk by chunk.

// Strobe synchroniser with rising-edge detect; one instance per host strobe.
module ptp_strobe_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic strobe,
    output logic pulse
);
    logic [SYNC_STAGES-1:0] sync_pipe;
    logic                   prev;

    // Shift the async strobe through the sync chain, keep the last value for edge detect
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_pipe <= '0;
            prev      <= 1'b0;
        end else begin
            sync_pipe <= {sync_pipe[SYNC_STAGES-2:0], strobe};
            prev      <= sync_pipe[SYNC_STAGES-1];
        end
    end

    assign pulse = sync_pipe[SYNC_STAGES-1] & ~prev;
endmodule

module ptp_stream_bridge #(
    parameter int BUS_W       = 8,
    parameter int WORD_W      = 32,
    parameter int OUT_WORDS   = 2,
    parameter int SYNC_STAGES = 2
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        clear_i,
    input  logic                        load_strobe_i,
    input  logic                        read_strobe_i,
    input  logic [BUS_W-1:0]            bus_i,
    input  logic [OUT_WORDS*WORD_W-1:0] word_i,
    output logic [WORD_W-1:0]           word_o,
    output logic                        word_valid_o,
    output logic [BUS_W-1:0]            bus_o,
    output logic                        frame_o
);
    localparam int CHUNKS = WORD_W / BUS_W;
    localparam int TOTAL  = OUT_WORDS * CHUNKS;
    localparam int ICW    = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
    localparam int OCW    = (TOTAL > 1) ? $clog2(TOTAL) : 1;

    localparam logic [ICW-1:0] IN_LAST  = ICW'(CHUNKS - 1);
    localparam logic [OCW-1:0] OUT_LAST = OCW'(TOTAL - 1);

    // Bit 0 = load strobe, bit 1 = read strobe
    logic [1:0] strobes;
    logic [1:0] events;
    logic       load_evt;
    logic       read_evt;

    assign strobes  = {read_strobe_i, load_strobe_i};
    assign load_evt = events[0];
    assign read_evt = events[1];

    ptp_strobe_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync [1:0] (
        .clk    (clk),
        .rst_n  (rst_n),
        .strobe (strobes),
        .pulse  (events)
    );

    logic [WORD_W-1:0]           asm_q;
    logic [WORD_W-1:0]           asm_next;
    logic [ICW-1:0]              in_cnt;
    logic [OUT_WORDS*WORD_W-1:0] shd;
    logic [OCW-1:0]              out_cnt;

    // New chunk enters at the LSB end, so the first chunk ends up as the MSB chunk
    generate
        if (CHUNKS == 1) begin : g_asm_single
            assign asm_next = bus_i;
        end else begin : g_asm_shift
            assign asm_next = {asm_q[WORD_W-BUS_W-1:0], bus_i};
        end
    endgenerate

    // Input path: shift chunks in; publish only complete words on word_o
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            asm_q        <= '0;
            in_cnt       <= '0;
            word_o       <= '0;
            word_valid_o <= 1'b0;
        end else if (clear_i) begin
            asm_q        <= '0;
            in_cnt       <= '0;
            word_valid_o <= 1'b0;
        end else if (load_evt) begin
            asm_q <= asm_next;
            if (in_cnt == IN_LAST) begin
                word_o       <= asm_next;
                word_valid_o <= 1'b1;
                in_cnt       <= '0;
            end else begin
                word_valid_o <= 1'b0;
                in_cnt       <= in_cnt + 1'b1;
            end
        end
    end

    // Output path: step through the shadow; reload it only at frame wrap or clear
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shd     <= '0;
            out_cnt <= '0;
        end else if (clear_i) begin
            shd     <= word_i;
            out_cnt <= '0;
        end else if (read_evt) begin
            if (out_cnt == OUT_LAST) begin
                out_cnt <= '0;
                shd     <= word_i;
            end else begin
                out_cnt <= out_cnt + 1'b1;
            end
        end
    end

    // Chunk select: word out_cnt/CHUNKS, chunk out_cnt%CHUNKS counted from the MSB
    always_comb begin
        bus_o = '0;
        for (int w = 0; w < OUT_WORDS; w++) begin
            for (int c = 0; c < CHUNKS; c++) begin
                if (out_cnt == OCW'(w * CHUNKS + c)) begin
                    bus_o = shd[w*WORD_W + WORD_W-1 - c*BUS_W -: BUS_W];
                end
            end
        end
    end

    assign frame_o = (out_cnt == '0);
endmodule

// File: tb/tb_ptp_stream_bridge.sv
// Bench for ptp_stream_bridge: two instances (default and narrow/deep params)
// driven by the same strobes. A reference model predicts every register update
// and its due cycle; a negedge monitor checks that every change is predicted.
module tb_ptp_stream_bridge;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clear_i = 1'b0;
    logic        load_s = 1'b0;
    logic        read_s = 1'b0;
    logic [7:0]  bus_a = '0;
    logic [3:0]  bus_b = '0;
    logic [63:0] wi_a = '0;
    logic [47:0] wi_b = '0;

    logic [31:0] word_a;
    logic        valid_a;
    logic [7:0]  bo_a;
    logic        frame_a;
    logic [15:0] word_b;
    logic        valid_b;
    logic [3:0]  bo_b;
    logic        frame_b;

    ptp_stream_bridge dut_a (
        .clk           (clk),
        .rst_n         (rst_n),
        .clear_i       (clear_i),
        .load_strobe_i (load_s),
        .read_strobe_i (read_s),
        .bus_i         (bus_a),
        .word_i        (wi_a),
        .word_o        (word_a),
        .word_valid_o  (valid_a),
        .bus_o         (bo_a),
        .frame_o       (frame_a)
    );

    ptp_stream_bridge #(.BUS_W(4), .WORD_W(16), .OUT_WORDS(3), .SYNC_STAGES(3)) dut_b (
        .clk           (clk),
        .rst_n         (rst_n),
        .clear_i       (clear_i),
        .load_strobe_i (load_s),
        .read_strobe_i (read_s),
        .bus_i         (bus_b),
        .word_i        (wi_b),
        .word_o        (word_b),
        .word_valid_o  (valid_b),
        .bus_o         (bo_b),
        .frame_o       (frame_b)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    bit rst_q = 1'b0;
    always @(posedge clk) begin
        cyc   <= cyc + 1;
        rst_q <= rst_n;
    end

    typedef struct {
        int          d;
        int          due;
        logic [63:0] val;
        bit          fr;
    } exp_t;

    exp_t wq[$];
    exp_t bq[$];
    int   checks = 0;
    int   errors = 0;
    bit   glitch = 1'b0;

    // Model parameters per instance (0 = default, 1 = narrow); both have 4 chunks per word
    int bw[2] = '{8, 4};
    int ww[2] = '{32, 16};
    int ow[2] = '{2, 3};
    int ss[2] = '{2, 3};

    logic [95:0] wi[2];
    logic [95:0] snap[2];
    logic [63:0] part[2];
    logic [63:0] lastw[2];
    int          pcnt[2];
    int          ocnt[2];

    logic [63:0] pw[2];
    logic        pv[2];
    logic [63:0] pb[2];
    logic        pf[2];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s cyc=%0d got %h want %h", name, cyc, got, want);
        end
    endtask

    // Chunk idx of the frame: word idx/4 from the LSB end, chunk idx%4 from that word's MSB
    function automatic logic [63:0] chunk(input int d, input int idx);
        logic [95:0] s;
        s = snap[d] >> ((idx / 4) * ww[d]);
        s = s >> ((3 - idx % 4) * bw[d]);
        s = s & ((96'd1 << bw[d]) - 96'd1);
        return s[63:0];
    endfunction

    function automatic void m_reset(input int d);
        part[d] = '0; lastw[d] = '0; pcnt[d] = 0; ocnt[d] = 0; snap[d] = '0;
    endfunction

    function automatic void m_load(input int d, input logic [7:0] v, input int due);
        logic [63:0] chunkv;
        chunkv  = 64'(v) & ((64'd1 << bw[d]) - 64'd1);
        part[d] = ((part[d] << bw[d]) | chunkv) & ((64'd1 << ww[d]) - 64'd1);
        pcnt[d]++;
        if (pcnt[d] == 4) begin
            pcnt[d]  = 0;
            lastw[d] = part[d];
            wq.push_back('{d, due, lastw[d], 1'b1});
        end else begin
            wq.push_back('{d, due, lastw[d], 1'b0});
        end
    endfunction

    function automatic void m_read(input int d, input int due);
        ocnt[d]++;
        if (ocnt[d] == ow[d] * 4) begin
            ocnt[d] = 0;
            snap[d] = wi[d];
        end
        bq.push_back('{d, due, chunk(d, ocnt[d]), ocnt[d] == 0});
    endfunction

    function automatic void m_clear(input int d, input int due);
        part[d] = '0; pcnt[d] = 0; ocnt[d] = 0; snap[d] = wi[d];
        wq.push_back('{d, due, lastw[d], 1'b0});
        bq.push_back('{d, due, chunk(d, 0), 1'b1});
    endfunction

    // Monitor: a due entry must match; with nothing due the output must hold
    task automatic mon_word(input int d, input logic [63:0] w, input logic v);
        int hit = -1;
        for (int i = wq.size() - 1; i >= 0; i--) begin
            if (wq[i].d == d && wq[i].due < cyc) begin
                checks++; errors++;
                $display("FAIL word_missed d=%0d cyc=%0d got none want %h", d, cyc, wq[i].val);
                wq.delete(i);
            end
        end
        for (int i = 0; i < wq.size(); i++)
            if (wq[i].d == d && wq[i].due == cyc) hit = i;
        if (hit >= 0) begin
            check($sformatf("word%0d", d), w, wq[hit].val);
            check($sformatf("word_valid%0d", d), 64'(v), 64'(wq[hit].fr));
            wq.delete(hit);
        end else begin
            check($sformatf("word_hold%0d", d), w, pw[d]);
            check($sformatf("valid_hold%0d", d), 64'(v), 64'(pv[d]));
        end
        pw[d] = w; pv[d] = v;
    endtask

    task automatic mon_bus(input int d, input logic [63:0] b, input logic f);
        int hit = -1;
        for (int i = bq.size() - 1; i >= 0; i--) begin
            if (bq[i].d == d && bq[i].due < cyc) begin
                checks++; errors++;
                $display("FAIL bus_missed d=%0d cyc=%0d got none want %h", d, cyc, bq[i].val);
                bq.delete(i);
            end
        end
        for (int i = 0; i < bq.size(); i++)
            if (bq[i].d == d && bq[i].due == cyc) hit = i;
        if (hit >= 0) begin
            check($sformatf("bus%0d", d), b, bq[hit].val);
            check($sformatf("frame%0d", d), 64'(f), 64'(bq[hit].fr));
            bq.delete(hit);
        end else if (!glitch) begin
            check($sformatf("bus_hold%0d", d), b, pb[d]);
            check($sformatf("frame_hold%0d", d), 64'(f), 64'(pf[d]));
        end
        pb[d] = b; pf[d] = f;
    endtask

    always @(negedge clk) begin
        if (rst_q) begin
            mon_word(0, 64'(word_a), valid_a);
            mon_word(1, 64'(word_b), valid_b);
            mon_bus(0, 64'(bo_a), frame_a);
            mon_bus(1, 64'(bo_b), frame_b);
        end else begin
            pw[0] = 64'(word_a); pv[0] = valid_a; pb[0] = 64'(bo_a); pf[0] = frame_a;
            pw[1] = 64'(word_b); pv[1] = valid_b; pb[1] = 64'(bo_b); pf[1] = frame_b;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_wi(input logic [63:0] a, input logic [47:0] b);
        wi[0] = 96'(a); wi[1] = 96'(b);
        wi_a  = a;      wi_b  = b;
    endtask

    // One strobe pulse (load, read or both), high 4 cycles and low 4 cycles
    task automatic step(input bit ld, input bit rd, input logic [7:0] v);
        int issue;
        bus_a = v;
        bus_b = v[3:0];
        issue = cyc;
        for (int d = 0; d < 2; d++) begin
            if (ld) m_load(d, v, issue + ss[d] + 1);
            if (rd) m_read(d, issue + ss[d] + 1);
        end
        load_s = ld;
        read_s = rd;
        tick(4);
        load_s = 1'b0;
        read_s = 1'b0;
        tick(4);
    endtask

    task automatic do_clear();
        int issue;
        issue   = cyc;
        clear_i = 1'b1;
        for (int d = 0; d < 2; d++) m_clear(d, issue + 1);
        tick(1);
        clear_i = 1'b0;
        tick(1);
    endtask

    // Clear held across the load event edges of both instances, so the event is dropped
    task automatic clear_collide(input logic [7:0] v);
        int issue;
        bus_a  = v;
        bus_b  = v[3:0];
        issue  = cyc;
        load_s = 1'b1;
        tick(2);
        clear_i = 1'b1;
        for (int d = 0; d < 2; d++) m_clear(d, issue + 3);
        tick(2);
        clear_i = 1'b0;
        load_s  = 1'b0;
        tick(4);
    endtask

    task automatic reset_checks(input string tag);
        check({tag, "_word_a"}, 64'(word_a), 64'd0);
        check({tag, "_valid_a"}, 64'(valid_a), 64'd0);
        check({tag, "_bus_a"}, 64'(bo_a), 64'd0);
        check({tag, "_frame_a"}, 64'(frame_a), 64'd1);
        check({tag, "_word_b"}, 64'(word_b), 64'd0);
        check({tag, "_valid_b"}, 64'(valid_b), 64'd0);
        check({tag, "_bus_b"}, 64'(bo_b), 64'd0);
        check({tag, "_frame_b"}, 64'(frame_b), 64'd1);
    endtask

    logic [7:0] seq1[9] = '{8'hCA, 8'hFE, 8'hBA, 8'hBE, 8'h00, 8'h00, 8'h00, 8'h1F, 8'h11};
    logic [7:0] seq2[8] = '{8'h11, 8'h11, 8'h11, 8'h00, 8'h00, 8'h00, 8'h00, 8'h11};

    initial begin
        int          issue;
        logic [63:0] ra;
        logic [63:0] rb;
        bit          ok;
        for (int d = 0; d < 2; d++) m_reset(d);
        set_wi('0, '0);

        // Reset and idle
        rst_n = 1'b0;
        tick(3);
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            reset_checks("idle");
        end

        // Word assembly
        step(1, 0, 8'h12);
        step(1, 0, 8'h34);
        step(1, 0, 8'h56);
        step(1, 0, 8'h78);
        check("asm_a", 64'(word_a), 64'h12345678);
        check("asm_b", 64'(word_b), 64'h2468);

        // Frame readout and snapshot coherence
        set_wi(64'h0000001F_CAFEBABE, 48'h3C5A_96E1_7B84);
        do_clear();
        check("frame_start_bus", 64'(bo_a), 64'(seq1[0]));
        check("frame_start_fr", 64'(frame_a), 64'd1);
        for (int i = 0; i < 8; i++) begin
            step(0, 1, 8'h00);
            if (i == 1) set_wi(64'h00000000_11111111, 48'h0123_4567_89AB);
            check($sformatf("seq1_bus%0d", i), 64'(bo_a), 64'(seq1[i+1]));
            check($sformatf("seq1_fr%0d", i), 64'(frame_a), 64'(i == 7));
        end
        for (int i = 0; i < 8; i++) begin
            step(0, 1, 8'h00);
            check($sformatf("seq2_bus%0d", i), 64'(bo_a), 64'(seq2[i]));
        end

        // Clear mid-word, colliding with a load event
        step(1, 0, 8'hAA);
        step(1, 0, 8'hBB);
        clear_collide(8'hCC);
        check("retain_a", 64'(word_a), 64'h12345678);
        for (int i = 1; i <= 4; i++) step(1, 0, 8'(i));
        check("clrword_a", 64'(word_a), 64'h01020304);
        check("clrword_b", 64'(word_b), 64'h1234);

        // Single-cycle read glitch: at most one step along the frame
        set_wi(64'hF0E1D2C3_B4A59687, 48'h1234_5678_9ABC);
        do_clear();
        glitch = 1'b1;
        read_s = 1'b1;
        tick(1);
        read_s = 1'b0;
        tick(8);
        ok = (64'(bo_a) == chunk(0, 0) && frame_a) || (64'(bo_a) == chunk(0, 1) && !frame_a);
        check("glitch_a", 64'(ok), 64'd1);
        ok = (64'(bo_b) == chunk(1, 0) && frame_b) || (64'(bo_b) == chunk(1, 1) && !frame_b);
        check("glitch_b", 64'(ok), 64'd1);
        glitch = 1'b0;
        do_clear();

        // Strobe held high across reset release gives exactly one event
        rst_n  = 1'b0;
        load_s = 1'b1;
        bus_a  = 8'h5A;
        bus_b  = 4'hA;
        tick(2);
        for (int d = 0; d < 2; d++) m_reset(d);
        rst_n = 1'b1;
        issue = cyc;
        for (int d = 0; d < 2; d++) m_load(d, 8'h5A, issue + ss[d] + 1);
        tick(1);
        reset_checks("rst_hold");
        tick(3);
        load_s = 1'b0;
        tick(4);

        // Reset mid-word: no partial word survives
        step(1, 0, 8'h9E);
        step(1, 0, 8'h4D);
        rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1;
        for (int d = 0; d < 2; d++) m_reset(d);
        reset_checks("rst_mid");
        for (int i = 0; i < 4; i++) step(1, 0, 8'hA0 + 8'(i));

        // Randomised mix of loads, reads, both, clears and word_i changes
        repeat (60) begin
            int r;
            r = $urandom_range(0, 9);
            if (r == 0) begin
                do_clear();
            end else if (r == 1) begin
                ra = {32'($urandom), 32'($urandom)};
                rb = {32'($urandom), 32'($urandom)};
                set_wi(ra, rb[47:0]);
            end else begin
                int m;
                m = $urandom_range(1, 3);
                step(m[0], m[1], 8'($urandom));
            end
        end

        tick(10);
        check("pending_words", 64'(wq.size()), 64'd0);
        check("pending_chunks", 64'(bq.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog cyc=%0d got timeout want finish", cyc);
        $fatal(1);
    end
endmodule
